// File: rtl/mips_pkg.sv
// Shared types for the CPU-side blocks: DMA command encoding and DMA FSM states.
package mips_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        D2S  = 2'b01,
        S2D  = 2'b10,
        RSVD = 2'b11
    } dma_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        D2S_REQ,
        D2S_WR,
        S2D_RD,
        S2D_REQ,
        FIN
    } dma_state_t;

    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/dma_ctrl.sv
// Word-at-a-time DMA engine moving data between DRAM (req/ready handshake)
// and a 1-cycle-latency SRAM. One FSM plus the address/count datapath.
module dma_ctrl
    import mips_pkg::*;
#(
    parameter int SRAM_AW = 14,
    parameter int DW      = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         dmaCmd,
    input  logic [31:0]        dmaSrcAddress,
    input  logic [31:0]        dmaDstAddress,
    input  logic [9:0]         dmaWidth,
    output logic               busy,
    output logic               done,
    output logic               dramReq,
    output logic               dramWe,
    output logic [31:0]        dramAddr,
    output logic [DW-1:0]      dramWData,
    input  logic               dramReady,
    input  logic [DW-1:0]      dramRData,
    output logic [SRAM_AW-1:0] sramAddr,
    output logic               sramWe,
    output logic [DW-1:0]      sramWData,
    input  logic [DW-1:0]      sramRData
);

    dma_state_t    state_q, state_d;
    logic [31:0]   src_q, src_d;
    logic [31:0]   dst_q, dst_d;
    logic [9:0]    cnt_q, cnt_d;
    logic [DW-1:0] data_q, data_d;
    logic          rdp_q, rdp_d;

    dma_cmd_t cmd;
    logic     cmd_ok;
    logic     last;

    assign cmd    = dma_cmd_t'(dmaCmd);
    assign cmd_ok = (cmd == D2S) || (cmd == S2D);
    assign last   = (cnt_q == 10'd1);
    assign busy   = (state_q != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            rdp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rdp_q   <= rdp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        rdp_d     = 1'b0;
        done      = 1'b0;
        dramReq   = 1'b0;
        dramWe    = 1'b0;
        dramAddr  = '0;
        dramWData = '0;
        sramAddr  = '0;
        sramWe    = 1'b0;
        sramWData = '0;
        case (state_q)
            IDLE: begin
                if (cmd_ok) begin
                    src_d = dmaSrcAddress;
                    dst_d = dmaDstAddress;
                    cnt_d = dmaWidth;
                    if (dmaWidth == 10'd0) state_d = FIN;
                    else if (cmd == D2S)   state_d = D2S_REQ;
                    else                   state_d = S2D_RD;
                end
            end
            D2S_REQ: begin
                dramReq  = 1'b1;
                dramAddr = src_q;
                if (dramReady) begin
                    data_d  = dramRData;
                    state_d = D2S_WR;
                end
            end
            D2S_WR: begin
                sramWe    = 1'b1;
                sramAddr  = dst_q[SRAM_AW+1:2];
                sramWData = data_q;
                src_d     = src_q + WORD_BYTES;
                dst_d     = dst_q + WORD_BYTES;
                cnt_d     = cnt_q - 10'd1;
                state_d   = last ? FIN : D2S_REQ;
            end
            S2D_RD: begin
                // Address is held for two cycles: issue, then capture the read data.
                sramAddr = src_q[SRAM_AW+1:2];
                if (rdp_q) begin
                    data_d  = sramRData;
                    state_d = S2D_REQ;
                end else begin
                    rdp_d = 1'b1;
                end
            end
            S2D_REQ: begin
                dramReq   = 1'b1;
                dramWe    = 1'b1;
                dramAddr  = dst_q;
                dramWData = data_q;
                if (dramReady) begin
                    src_d   = src_q + WORD_BYTES;
                    dst_d   = dst_q + WORD_BYTES;
                    cnt_d   = cnt_q - 10'd1;
                    state_d = last ? FIN : S2D_RD;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl with a latency-programmable DRAM responder and a sync-read SRAM.
module tb_dma_ctrl;

    localparam int SRAM_AW = 14;
    localparam int DW      = 32;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [1:0]         dmaCmd = 2'b00;
    logic [31:0]        dmaSrcAddress = '0;
    logic [31:0]        dmaDstAddress = '0;
    logic [9:0]         dmaWidth = '0;
    logic               busy, done;
    logic               dramReq, dramWe;
    logic [31:0]        dramAddr;
    logic [DW-1:0]      dramWData;
    logic               dramReady = 1'b0;
    logic [DW-1:0]      dramRData = '0;
    logic [SRAM_AW-1:0] sramAddr;
    logic               sramWe;
    logic [DW-1:0]      sramWData;
    logic [DW-1:0]      sramRData;

    dma_ctrl #(.SRAM_AW(SRAM_AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .dmaCmd(dmaCmd), .dmaSrcAddress(dmaSrcAddress), .dmaDstAddress(dmaDstAddress),
        .dmaWidth(dmaWidth), .busy(busy), .done(done),
        .dramReq(dramReq), .dramWe(dramWe), .dramAddr(dramAddr), .dramWData(dramWData),
        .dramReady(dramReady), .dramRData(dramRData),
        .sramAddr(sramAddr), .sramWe(sramWe), .sramWData(sramWData), .sramRData(sramRData)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // ---------------- memory models and monitors ----------------
    logic [DW-1:0] sram_mem [0:(1<<SRAM_AW)-1];
    logic [DW-1:0] sram_rd = '0;
    assign sramRData = sram_rd;

    int lat = 2;
    int wait_cnt = 0;
    int done_cnt = 0, sram_we_cnt = 0, req_cnt = 0, bad_we_cnt = 0;
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];

    function automatic logic [31:0] dram_val(input logic [31:0] a);
        case (a)
            32'h100: return 32'hA;
            32'h104: return 32'hB;
            32'h108: return 32'hC;
            default: return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (sramWe) sram_mem[sramAddr] <= sramWData;
        sram_rd <= sram_mem[sramAddr];
        if (dramReq && dramReady) wait_cnt <= 0;
        else if (dramReq) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (dramReq && dramReady && dramWe) begin
            wr_addr.push_back(dramAddr);
            wr_data.push_back(dramWData);
        end
        if (done) done_cnt <= done_cnt + 1;
        if (sramWe) sram_we_cnt <= sram_we_cnt + 1;
        if (dramReq) req_cnt <= req_cnt + 1;
        if (dramWe != dramReq && dramWe) bad_we_cnt <= bad_we_cnt + 1;
    end

    always @(negedge clk) begin
        dramReady = dramReq && (wait_cnt >= lat);
        dramRData = dram_val(dramAddr);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [1:0] c, input logic [31:0] s, input logic [31:0] d,
                         input logic [9:0] w);
        dmaCmd = c; dmaSrcAddress = s; dmaDstAddress = d; dmaWidth = w;
        @(negedge clk);
        dmaCmd = 2'b00;
    endtask

    task automatic run_idle(input string tag, input int maxc);
        int c = 0;
        while (busy && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    int d0, w0, r0, q0, b0;
    logic [31:0] a_hold, d_hold;

    initial begin
        for (int i = 0; i < (1 << SRAM_AW); i++) sram_mem[i] = '0;
        // Reset state
        #12;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_req",  {31'd0, dramReq}, 0);
        chk("rst_swe",  {31'd0, sramWe}, 0);
        chk("rst_daddr", dramAddr, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // d2s, 3 words, ready after 2 cycles
        d0 = done_cnt; w0 = sram_we_cnt;
        start(2'b01, 32'h100, 32'h40, 10'd3);
        chk("d2s_busy", {31'd0, busy}, 1);
        run_idle("d2s_timeout", 100);
        chk("d2s_w16", sram_mem[16], 32'hA);
        chk("d2s_w17", sram_mem[17], 32'hB);
        chk("d2s_w18", sram_mem[18], 32'hC);
        chk("d2s_done", done_cnt - d0, 1);
        chk("d2s_swe", sram_we_cnt - w0, 3);

        // s2d, 2 words from SRAM 4..5
        sram_mem[4] = 32'h11; sram_mem[5] = 32'h22;
        d0 = done_cnt; q0 = wr_addr.size(); b0 = bad_we_cnt; w0 = sram_we_cnt;
        start(2'b10, 32'h10, 32'h2000, 10'd2);
        run_idle("s2d_timeout", 100);
        chk("s2d_nwr", wr_addr.size() - q0, 2);
        chk("s2d_a0", wr_addr[q0], 32'h2000);
        chk("s2d_d0", wr_data[q0], 32'h11);
        chk("s2d_a1", wr_addr[q0+1], 32'h2004);
        chk("s2d_d1", wr_data[q0+1], 32'h22);
        chk("s2d_badwe", bad_we_cnt - b0, 0);
        chk("s2d_swe", sram_we_cnt - w0, 0);
        chk("s2d_done", done_cnt - d0, 1);

        // width 0: straight to FIN, no memory traffic
        r0 = req_cnt; w0 = sram_we_cnt;
        start(2'b01, 32'h300, 32'h300, 10'd0);
        chk("w0_done_hi", {31'd0, done}, 1);
        chk("w0_busy_hi", {31'd0, busy}, 1);
        @(negedge clk);
        chk("w0_done_lo", {31'd0, done}, 0);
        chk("w0_busy_lo", {31'd0, busy}, 0);
        chk("w0_req", req_cnt - r0, 0);
        chk("w0_swe", sram_we_cnt - w0, 0);

        // reserved command ignored, then s2d held asserted during its own transfer
        start(2'b11, 32'h10, 32'h10, 10'd1);
        chk("rsvd_busy", {31'd0, busy}, 0);
        d0 = done_cnt; q0 = wr_addr.size();
        dmaCmd = 2'b10; dmaSrcAddress = 32'h10; dmaDstAddress = 32'h3000; dmaWidth = 10'd1;
        for (int c = 0; c < 100 && !done; c++) @(negedge clk);
        dmaCmd = 2'b00;
        run_idle("hold_timeout", 10);
        repeat (3) @(negedge clk);
        chk("hold_done", done_cnt - d0, 1);
        chk("hold_nwr", wr_addr.size() - q0, 1);
        chk("hold_busy", {31'd0, busy}, 0);

        // reset during DRAM request of word 2 of 4
        d0 = done_cnt; w0 = sram_we_cnt;
        start(2'b01, 32'h200, 32'h80, 10'd4);
        for (int c = 0; c < 100 && !((sram_we_cnt - w0) == 1 && dramReq); c++) @(negedge clk);
        chk("mid_reached", {31'd0, dramReq}, 1);
        reset = 1'b0;
        #1;
        chk("mid_busy", {31'd0, busy}, 0);
        chk("mid_req",  {31'd0, dramReq}, 0);
        chk("mid_addr", dramAddr, 0);
        chk("mid_swe",  {31'd0, sramWe}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_nodone", done_cnt - d0, 0);
        chk("mid_w32", sram_mem[32], 32'h5A5A_0200);
        d0 = done_cnt;
        start(2'b01, 32'h104, 32'h0, 10'd1);
        run_idle("post_timeout", 50);
        chk("post_w0", sram_mem[0], 32'hB);
        chk("post_done", done_cnt - d0, 1);

        // DRAM stall: 20 cycles of ready low on a write request
        lat = 20;
        q0 = wr_addr.size();
        start(2'b10, 32'h10, 32'h4000, 10'd1);
        for (int c = 0; c < 20 && !dramReq; c++) @(negedge clk);
        chk("stall_req", {31'd0, dramReq}, 1);
        a_hold = dramAddr; d_hold = dramWData;
        chk("stall_a0", a_hold, 32'h4000);
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            chk("stall_addr", dramAddr, a_hold);
            chk("stall_data", dramWData, d_hold);
            chk("stall_busy", {31'd0, busy}, 1);
        end
        run_idle("stall_timeout", 20);
        chk("stall_nwr", wr_addr.size() - q0, 1);
        chk("stall_wd", wr_data[q0], 32'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
